// File: rtl/jtdd2_mcu_ctrl_pkg.sv
// Shared definitions for the Double Dragon 2 sub-CPU control block:
// handshake state encoding plus status and control register bit positions.
package jtdd2_mcu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } hs_state_t;

  localparam int ST_GNT  = 0;
  localparam int ST_IRQ  = 1;
  localparam int ST_TO   = 2;
  localparam int ST_RST  = 3;

  localparam int CT_RSTB = 0;
  localparam int CT_HALT = 1;

  // An access acts once: on its first qualified cen, never on later ones.
  function automatic logic first_wr(input logic wr, input logic last);
    return wr & ~last;
  endfunction

endpackage

// File: rtl/jtdd2_mcu_ctrl_if.sv
// Main CPU side of the sub-CPU control block: write strobes, selects,
// gated shared-RAM select, interrupt line and status byte.
interface jtdd2_mcu_ctrl_if;
  logic       main_cen;
  logic       main_wrn;
  logic [7:0] main_dout;
  logic       ctrl_cs;
  logic       nmi_cs;
  logic       irqack_cs;
  logic       com_cs_in;
  logic       com_cs;
  logic       main_irq;
  logic [7:0] st_dout;

  modport master (
    output main_cen, main_wrn, main_dout, ctrl_cs, nmi_cs, irqack_cs, com_cs_in,
    input  com_cs, main_irq, st_dout
  );

  modport slave (
    input  main_cen, main_wrn, main_dout, ctrl_cs, nmi_cs, irqack_cs, com_cs_in,
    output com_cs, main_irq, st_dout
  );
endinterface

// File: rtl/jtdd2_mcu_hshake.sv
// Bus-halt handshake with the sub CPU: request, grant tracking via the
// active-low bus acknowledge, release, and a sticky grant-timeout flag.
module jtdd2_mcu_hshake
  import jtdd2_mcu_pkg::*;
#(
  parameter int             TOW     = 8,
  parameter logic [TOW-1:0] HALT_TO = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic main_cen,
  input  logic halt_req,
  input  logic mcu_rstb,
  input  logic mcu_ban,
  output logic mcu_halt,
  output logic granted,
  output logic timeout
);

  hs_state_t      state_q, state_d;
  logic [TOW-1:0] cnt_q, cnt_d;
  logic           to_q, to_d;
  logic           halt_q, halt_d;
  logic           gnt_q, gnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    if (!mcu_rstb) begin
      state_d = IDLE;
      cnt_d   = '0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (halt_req) begin
          state_d = REQ;
          cnt_d   = '0;
        end
        REQ: begin
          if (!halt_req) begin
            state_d = REL;
          end else if (!mcu_ban) begin
            state_d = HELD;
            to_d    = 1'b0;
          end else if (cnt_q == HALT_TO) begin
            // Counter parks at the limit so the flag cannot be lost to wrap-around
            to_d = 1'b1;
          end else if (main_cen) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!halt_req) begin
            state_d = REL;
          end else if (mcu_ban) begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
        REL: if (mcu_ban) state_d = IDLE;
      endcase
    end
    halt_d = (state_d == REQ) || (state_d == HELD);
    gnt_d  = (state_d == HELD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      halt_q  <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      halt_q  <= halt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign mcu_halt = halt_q;
  assign granted  = gnt_q;
  assign timeout  = to_q;

endmodule

// File: rtl/jtdd2_mcu_ctrl.sv
// Main-CPU-side control of the Double Dragon 2 sub CPU: register write decode,
// NMI strobe, sub-to-main IRQ latch, shared-RAM gating and status byte.
module jtdd2_mcu_ctrl
  import jtdd2_mcu_pkg::*;
#(
  parameter int             TOW     = 8,
  parameter logic [TOW-1:0] HALT_TO = 8'd255
) (
  input  logic             clk,
  input  logic             rst,
  jtdd2_mcu_ctrl_if.slave  bus,
  input  logic             mcu_ban,
  input  logic             mcu_irqmain,
  output logic             mcu_rstb,
  output logic             mcu_halt,
  output logic             mcu_nmi_set
);

  logic       ctrl_last_q, ctrl_last_d;
  logic       nmi_last_q,  nmi_last_d;
  logic       ack_last_q,  ack_last_d;
  logic       rstb_q,      rstb_d;
  logic       halt_req_q,  halt_req_d;
  logic       nmi_q,       nmi_d;
  logic       irqm_q,      irqm_d;
  logic       irq_q,       irq_d;
  logic [7:0] st_q,        st_d;

  logic ctrl_acc, nmi_acc, ack_acc;
  logic ctrl_fire, nmi_fire, ack_fire;
  logic granted, timeout;
  logic unused_dout;

  assign unused_dout = ^bus.main_dout[7:2];

  // A select's last flag holds from its first qualified cen until cs or the write strobe drops
  always_comb begin
    ctrl_acc    = bus.ctrl_cs   & ~bus.main_wrn;
    nmi_acc     = bus.nmi_cs    & ~bus.main_wrn;
    ack_acc     = bus.irqack_cs & ~bus.main_wrn;
    ctrl_fire   = first_wr(bus.main_cen & ctrl_acc, ctrl_last_q);
    nmi_fire    = first_wr(bus.main_cen & nmi_acc,  nmi_last_q);
    ack_fire    = first_wr(bus.main_cen & ack_acc,  ack_last_q);
    ctrl_last_d = ctrl_acc & (ctrl_last_q | bus.main_cen);
    nmi_last_d  = nmi_acc  & (nmi_last_q  | bus.main_cen);
    ack_last_d  = ack_acc  & (ack_last_q  | bus.main_cen);

    rstb_d     = ctrl_fire ? bus.main_dout[CT_RSTB] : rstb_q;
    halt_req_d = ctrl_fire ? bus.main_dout[CT_HALT] : halt_req_q;
    nmi_d      = nmi_fire & rstb_q;

    // A new rising edge outranks an acknowledge landing in the same clk
    irqm_d = mcu_irqmain;
    if (!rstb_q)                     irq_d = 1'b0;
    else if (mcu_irqmain && !irqm_q) irq_d = 1'b1;
    else if (ack_fire)               irq_d = 1'b0;
    else                             irq_d = irq_q;

    st_d         = 8'h00;
    st_d[ST_GNT] = granted;
    st_d[ST_IRQ] = irq_q;
    st_d[ST_TO]  = timeout;
    st_d[ST_RST] = rstb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_last_q <= 1'b0;
      nmi_last_q  <= 1'b0;
      ack_last_q  <= 1'b0;
      rstb_q      <= 1'b0;
      halt_req_q  <= 1'b0;
      nmi_q       <= 1'b0;
      irqm_q      <= 1'b0;
      irq_q       <= 1'b0;
      st_q        <= 8'h00;
    end else begin
      ctrl_last_q <= ctrl_last_d;
      nmi_last_q  <= nmi_last_d;
      ack_last_q  <= ack_last_d;
      rstb_q      <= rstb_d;
      halt_req_q  <= halt_req_d;
      nmi_q       <= nmi_d;
      irqm_q      <= irqm_d;
      irq_q       <= irq_d;
      st_q        <= st_d;
    end
  end

  jtdd2_mcu_hshake #(
    .TOW     (TOW),
    .HALT_TO (HALT_TO)
  ) u_hs (
    .clk      (clk),
    .rst      (rst),
    .main_cen (bus.main_cen),
    .halt_req (halt_req_q),
    .mcu_rstb (rstb_q),
    .mcu_ban  (mcu_ban),
    .mcu_halt (mcu_halt),
    .granted  (granted),
    .timeout  (timeout)
  );

  assign mcu_rstb     = rstb_q;
  assign mcu_nmi_set  = nmi_q;
  assign bus.com_cs   = bus.com_cs_in & granted;
  assign bus.main_irq = irq_q;
  assign bus.st_dout  = st_q;

endmodule

// File: tb/tb_jtdd2_mcu_ctrl.sv
// Scenario bench for jtdd2_mcu_ctrl plus a randomized run checked against a
// register-level model of the main CPU's view of the sub-CPU controls.
module tb_jtdd2_mcu_ctrl;
  import jtdd2_mcu_pkg::*;

  localparam int SEL_CTRL = 0;
  localparam int SEL_NMI  = 1;
  localparam int SEL_ACK  = 2;

  logic clk = 1'b0;
  logic rst;
  logic mcu_ban, mcu_irqmain;
  logic mcu_rstb, mcu_halt, mcu_nmi_set;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nmi_pulses = 0;

  jtdd2_mcu_ctrl_if bus ();

  jtdd2_mcu_ctrl #(
    .TOW     (8),
    .HALT_TO (8'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mcu_ban     (mcu_ban),
    .mcu_irqmain (mcu_irqmain),
    .mcu_rstb    (mcu_rstb),
    .mcu_halt    (mcu_halt),
    .mcu_nmi_set (mcu_nmi_set)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mcu_nmi_set === 1'b1) nmi_pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic deselect();
    bus.ctrl_cs   = 1'b0;
    bus.nmi_cs    = 1'b0;
    bus.irqack_cs = 1'b0;
    bus.main_wrn  = 1'b1;
    bus.main_cen  = 1'b0;
  endtask

  task automatic bus_write(input int sel, input logic [7:0] d, input int ncen);
    bus.main_dout = d;
    bus.main_wrn  = 1'b0;
    bus.ctrl_cs   = (sel == SEL_CTRL);
    bus.nmi_cs    = (sel == SEL_NMI);
    bus.irqack_cs = (sel == SEL_ACK);
    for (int k = 0; k < ncen; k++) begin
      bus.main_cen = 1'b1;
      step();
      bus.main_cen = 1'b0;
      step();
    end
    deselect();
    step();
  endtask

  task automatic cen_pulse();
    bus.main_cen = 1'b1;
    step();
    bus.main_cen = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    deselect();
    bus.main_dout = 8'h00;
    bus.com_cs_in = 1'b1;
    mcu_ban = 1'b1;
    mcu_irqmain = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_cmp++; if (mcu_rstb !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rstb: got %b want 0", mcu_rstb); end
    n_cmp++; if (mcu_halt !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_halt: got %b want 0", mcu_halt); end
    n_cmp++; if (mcu_nmi_set !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_nmi: got %b want 0", mcu_nmi_set); end
    n_cmp++; if (bus.com_cs !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_com_cs: got %b want 0", bus.com_cs); end
    n_cmp++; if (bus.main_irq !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_irq: got %b want 0", bus.main_irq); end
    n_cmp++; if (bus.st_dout !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_st: got %h want 00", bus.st_dout); end
    bus.com_cs_in = 1'b0;
  endtask

  task automatic test_ctrl_rstb();
    bus.main_dout = 8'h01;
    bus.main_wrn  = 1'b0;
    bus.ctrl_cs   = 1'b1;
    bus.main_cen  = 1'b1;
    step();
    n_cmp++; if (mcu_rstb !== 1'b1) begin n_bad++; $display("[TB] FAIL ctrl_rstb_latency: got %b want 1", mcu_rstb); end
    bus.main_cen = 1'b0;
    step();
    n_cmp++; if (bus.st_dout !== 8'h08) begin n_bad++; $display("[TB] FAIL ctrl_st: got %h want 08", bus.st_dout); end
    n_cmp++; if ({mcu_halt, mcu_nmi_set, bus.com_cs, bus.main_irq} !== 4'b0000) begin
      n_bad++; $display("[TB] FAIL ctrl_side_effects: got %b want 0000", {mcu_halt, mcu_nmi_set, bus.com_cs, bus.main_irq});
    end
    deselect();
    step();
  endtask

  task automatic test_handshake();
    mcu_ban = 1'b1;
    bus.com_cs_in = 1'b1;
    bus_write(SEL_CTRL, 8'h03, 1);
    n_cmp++; if (mcu_halt !== 1'b1) begin n_bad++; $display("[TB] FAIL hs_halt_req: got %b want 1", mcu_halt); end
    n_cmp++; if (bus.com_cs !== 1'b0) begin n_bad++; $display("[TB] FAIL hs_com_cs_ungranted: got %b want 0", bus.com_cs); end
    repeat (10) cen_pulse();
    mcu_ban = 1'b0;
    step();
    n_cmp++; if (bus.com_cs !== 1'b1) begin n_bad++; $display("[TB] FAIL hs_com_cs_granted: got %b want 1", bus.com_cs); end
    step();
    n_cmp++; if (bus.st_dout[ST_GNT] !== 1'b1) begin n_bad++; $display("[TB] FAIL hs_st_gnt: got %b want 1", bus.st_dout[ST_GNT]); end
    bus.com_cs_in = 1'b0;
    #1;
    n_cmp++; if (bus.com_cs !== 1'b0) begin n_bad++; $display("[TB] FAIL hs_com_cs_follow: got %b want 0", bus.com_cs); end
    bus.com_cs_in = 1'b1;
    bus_write(SEL_CTRL, 8'h01, 1);
    n_cmp++; if (mcu_halt !== 1'b0) begin n_bad++; $display("[TB] FAIL hs_release_halt: got %b want 0", mcu_halt); end
    n_cmp++; if (bus.com_cs !== 1'b0) begin n_bad++; $display("[TB] FAIL hs_release_com_cs: got %b want 0", bus.com_cs); end
    n_cmp++; if (dut.u_hs.state_q !== REL) begin n_bad++; $display("[TB] FAIL hs_state_rel: got %0d want %0d", dut.u_hs.state_q, REL); end
    mcu_ban = 1'b1;
    step();
    n_cmp++; if (dut.u_hs.state_q !== IDLE) begin n_bad++; $display("[TB] FAIL hs_state_idle: got %0d want %0d", dut.u_hs.state_q, IDLE); end
    bus.com_cs_in = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    mcu_ban = 1'b1;
    bus_write(SEL_CTRL, 8'h03, 1);
    repeat (3) cen_pulse();
    repeat (2) step();
    n_cmp++; if (bus.st_dout[ST_TO] !== 1'b0) begin n_bad++; $display("[TB] FAIL to_early: got %b want 0", bus.st_dout[ST_TO]); end
    cen_pulse();
    repeat (2) step();
    n_cmp++; if (bus.st_dout[ST_TO] !== 1'b1) begin n_bad++; $display("[TB] FAIL to_set: got %b want 1", bus.st_dout[ST_TO]); end
    n_cmp++; if (mcu_halt !== 1'b1) begin n_bad++; $display("[TB] FAIL to_still_req: got %b want 1", mcu_halt); end
    mcu_ban = 1'b0;
    repeat (2) step();
    n_cmp++; if (bus.st_dout !== 8'h09) begin n_bad++; $display("[TB] FAIL to_grant_st: got %h want 09", bus.st_dout); end
    bus_write(SEL_CTRL, 8'h01, 1);
    mcu_ban = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_nmi();
    int p0;
    p0 = nmi_pulses;
    bus_write(SEL_NMI, 8'h00, 3);
    step();
    n_cmp++; if (nmi_pulses - p0 !== 1) begin n_bad++; $display("[TB] FAIL nmi_one_pulse: got %0d want 1", nmi_pulses - p0); end
    bus_write(SEL_CTRL, 8'h00, 1);
    p0 = nmi_pulses;
    bus_write(SEL_NMI, 8'h00, 3);
    step();
    n_cmp++; if (nmi_pulses - p0 !== 0) begin n_bad++; $display("[TB] FAIL nmi_in_reset: got %0d want 0", nmi_pulses - p0); end
    bus_write(SEL_CTRL, 8'h01, 1);
  endtask

  task automatic test_irq();
    mcu_irqmain = 1'b1;
    step();
    n_cmp++; if (bus.main_irq !== 1'b1) begin n_bad++; $display("[TB] FAIL irq_latency: got %b want 1", bus.main_irq); end
    repeat (19) step();
    mcu_irqmain = 1'b0;
    repeat (2) step();
    n_cmp++; if (bus.st_dout[ST_IRQ] !== 1'b1) begin n_bad++; $display("[TB] FAIL irq_st: got %b want 1", bus.st_dout[ST_IRQ]); end
    mcu_irqmain   = 1'b1;
    bus.irqack_cs = 1'b1;
    bus.main_wrn  = 1'b0;
    bus.main_cen  = 1'b1;
    step();
    bus.main_cen = 1'b0;
    step();
    n_cmp++; if (bus.main_irq !== 1'b1) begin n_bad++; $display("[TB] FAIL irq_set_wins: got %b want 1", bus.main_irq); end
    deselect();
    mcu_irqmain = 1'b0;
    step();
    bus_write(SEL_ACK, 8'h00, 2);
    n_cmp++; if (bus.main_irq !== 1'b0) begin n_bad++; $display("[TB] FAIL irq_ack: got %b want 0", bus.main_irq); end
  endtask

  task automatic test_reset_in_held();
    mcu_ban = 1'b0;
    mcu_irqmain = 1'b1;
    repeat (2) step();
    mcu_irqmain = 1'b0;
    bus_write(SEL_CTRL, 8'h03, 1);
    bus.com_cs_in = 1'b1;
    #1;
    n_cmp++; if (bus.com_cs !== 1'b1 || bus.main_irq !== 1'b1) begin
      n_bad++; $display("[TB] FAIL held_setup: got com_cs=%b irq=%b want 1 1", bus.com_cs, bus.main_irq);
    end
    bus.main_dout = 8'h02;
    bus.main_wrn  = 1'b0;
    bus.ctrl_cs   = 1'b1;
    bus.main_cen  = 1'b1;
    step();
    deselect();
    step();
    n_cmp++; if (dut.u_hs.state_q !== IDLE) begin n_bad++; $display("[TB] FAIL held_rst_state: got %0d want %0d", dut.u_hs.state_q, IDLE); end
    n_cmp++; if ({mcu_rstb, mcu_halt, bus.com_cs, bus.main_irq} !== 4'b0000) begin
      n_bad++; $display("[TB] FAIL held_rst_outputs: got %b want 0000", {mcu_rstb, mcu_halt, bus.com_cs, bus.main_irq});
    end
    bus.com_cs_in = 1'b0;
    mcu_ban = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic       exp_rstb, exp_hreq, exp_irq;
    logic [7:0] d;
    int         op, p0, exp_nmi;
    mcu_ban = 1'b1;
    bus_write(SEL_CTRL, 8'h00, 1);
    exp_rstb = 1'b0;
    exp_hreq = 1'b0;
    exp_irq  = 1'b0;
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 3));
      p0 = nmi_pulses;
      exp_nmi = 0;
      case (op)
        0: begin
          d = 8'($urandom);
          bus_write(SEL_CTRL, d, int'($urandom_range(1, 3)));
          exp_rstb = d[0];
          exp_hreq = d[1];
          if (!exp_rstb) exp_irq = 1'b0;
        end
        1: begin
          bus_write(SEL_NMI, 8'($urandom), int'($urandom_range(1, 3)));
          exp_nmi = exp_rstb ? 1 : 0;
        end
        2: begin
          mcu_irqmain = 1'b1;
          repeat ($urandom_range(2, 5)) step();
          mcu_irqmain = 1'b0;
          if (exp_rstb) exp_irq = 1'b1;
        end
        default: begin
          bus_write(SEL_ACK, 8'($urandom), int'($urandom_range(1, 3)));
          exp_irq = 1'b0;
        end
      endcase
      repeat (4) step();
      n_cmp++; if (mcu_rstb !== exp_rstb) begin n_bad++; $display("[TB] FAIL rnd_rstb it=%0d: got %b want %b", it, mcu_rstb, exp_rstb); end
      n_cmp++; if (bus.main_irq !== exp_irq) begin n_bad++; $display("[TB] FAIL rnd_irq it=%0d: got %b want %b", it, bus.main_irq, exp_irq); end
      n_cmp++; if (mcu_halt !== (exp_hreq & exp_rstb)) begin n_bad++; $display("[TB] FAIL rnd_halt it=%0d: got %b want %b", it, mcu_halt, exp_hreq & exp_rstb); end
      n_cmp++; if ({bus.st_dout[ST_RST], bus.st_dout[ST_IRQ], bus.st_dout[ST_GNT]} !== {exp_rstb, exp_irq, 1'b0}) begin
        n_bad++; $display("[TB] FAIL rnd_st it=%0d: got %h want rst=%b irq=%b gnt=0", it, bus.st_dout, exp_rstb, exp_irq);
      end
      n_cmp++; if (nmi_pulses - p0 !== exp_nmi) begin n_bad++; $display("[TB] FAIL rnd_nmi it=%0d: got %0d want %0d", it, nmi_pulses - p0, exp_nmi); end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_rstb();
    test_handshake();
    test_timeout();
    test_nmi();
    test_irq();
    test_reset_in_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
